if_id_queue: RTL and testbench

- Instruction queue between the fetch stage (PC/ibus front end) and the decode stage.
- Buffers fetched {instrAddr, instr} pairs so that ibus latency and decode stalls (load-use hold, ok_to_proceed_overall low) are decoupled.
- Decode pops in order.
- A redirect (branch/jump resolve) flushes all buffered entries.

---
 rtl/if_id_queue.sv | 173 +++++++++++++++++
 tb/tb_if_id_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// ---------------------------------------------------------------------------
// if_id_queue
//   Instruction queue between the fetch stage and the decode stage. It holds
//   fetched {instrAddr, instr} pairs in a circular buffer so that ibus latency
//   and decode stalls are decoupled. Decode pops in strict FIFO order. A
//   redirect (flush) discards every buffered entry.
//
// Parameters
//   DEPTH : number of entries (power of two, >= 2)
//   AW    : instruction address width
//
// Ports
//   clk         : clock, all state updates on the rising edge
//   rst         : synchronous active-high reset
//   in_valid    : fetch presents an instruction
//   in_ready    : queue can accept (not full)
//   in_addr     : instrAddr of the fetched instruction
//   in_instr    : fetched instruction word
//   out_valid   : head entry valid for decode
//   out_ready   : decode consumes the head this cycle
//   out_addr    : head instrAddr
//   out_pcPlus4 : out_addr + 4 (modulo 2^AW)
//   out_instr   : head instruction word
//   flush       : redirect, discard all entries
//   count       : current occupancy
//
// Configuration macro
//   IF_ID_QUEUE_BYPASS_EN : when defined, an empty queue passes the fetch
//   input straight to the outputs in the same cycle (zero-cycle latency).
//   When undefined, fetch-to-decode latency is always at least one cycle.
// ---------------------------------------------------------------------------
`default_nettype none

module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_addr,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW-1:0]              out_addr,
  output logic [AW-1:0]              out_pcPlus4,
  output logic [31:0]                out_instr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_addr_mem  [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_bypass_take;
  logic          w_out_valid;
  logic [AW-1:0] w_out_addr;
  logic [31:0]   w_out_instr;

  assign w_empty  = (r_count == {CW{1'b0}});
  assign w_full   = (r_count == CW'(DEPTH));
  assign in_ready = ~w_full;

  // Bypass consumption: entry goes straight to decode, nothing is stored.
`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass_take = w_empty & in_valid & out_ready & ~flush;
`else
  assign w_bypass_take = 1'b0;
`endif

  // A pop only ever retires a stored entry, never a bypassed one.
  assign w_push = in_valid & ~w_full & ~flush & ~w_bypass_take;
  assign w_pop  = ~w_empty & out_ready & ~flush;

  // Output selection: head entry, or the live fetch input when bypassing.
  always_comb begin
    w_out_valid = ~w_empty;
    w_out_addr  = r_addr_mem[r_head];
    w_out_instr = r_instr_mem[r_head];
`ifdef IF_ID_QUEUE_BYPASS_EN
    if (w_empty && in_valid) begin
      w_out_valid = 1'b1;
      w_out_addr  = in_addr;
      w_out_instr = in_instr;
    end else begin
      w_out_valid = ~w_empty;
      w_out_addr  = r_addr_mem[r_head];
      w_out_instr = r_instr_mem[r_head];
    end
`endif
  end

  assign out_valid   = w_out_valid;
  assign out_addr    = w_out_addr;
  assign out_instr   = w_out_instr;
  assign out_pcPlus4 = w_out_addr + AW'(4);
  assign count       = r_count;

  // Entry storage: contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_mem[r_tail]  <= in_addr;
      r_instr_mem[r_tail] <= in_instr;
    end
  end

  // Pointer and occupancy state; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  if_id_queue_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .count (r_count)
  );

endmodule

// ---------------------------------------------------------------------------
// if_id_queue_chk
//   Simulation-only occupancy check for if_id_queue.
//
// Ports
//   clk   : clock
//   rst   : synchronous active-high reset
//   count : queue occupancy to be checked against DEPTH
// ---------------------------------------------------------------------------
module if_id_queue_chk #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  a_count_bound : assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));

endmodule

`default_nettype wire

// File: tb/tb_if_id_queue.sv
`timescale 1ns/1ps

module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 64;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [31:0]   in_instr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [AW-1:0] out_pcPlus4;
  logic [31:0]   out_instr;
  logic          flush;
  logic [2:0]    count;

  int n_checks;
  int n_errors;

  if_id_queue #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_addr     (in_addr),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_pcPlus4 (out_pcPlus4),
    .out_instr   (out_instr),
    .flush       (flush),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input logic [63:0] a, input logic [31:0] ins);
    in_valid = 1'b1;
    in_addr  = a;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  logic acc;
  logic [63:0] exp_a;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_addr   = 64'h0;
    in_instr  = 32'h0;
    out_ready = 1'b0;
    flush     = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: single push, one-cycle latency, then popped
    out_ready = 1'b1;
    push_hold(64'h8000_0000, 32'h0000_0013);
    check_eq("t1_valid", 64'(out_valid), 64'd1);
    check_eq("t1_addr", out_addr, 64'h8000_0000);
    check_eq("t1_pc4", out_pcPlus4, 64'h8000_0004);
    check_eq("t1_instr", 64'(out_instr), 64'h13);
    check_eq("t1_count", 64'(count), 64'd1);
    tick();
    check_eq("t1_count_after", 64'(count), 64'd0);
    check_eq("t1_valid_after", 64'(out_valid), 64'd0);

    // 2: fill while stalled, fifth held, then drain in order
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_hold(64'h8000_0000 + 64'(4 * i), 32'h100 + 32'(i));
    end
    check_eq("t2_full_count", 64'(count), 64'd4);
    check_eq("t2_full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_addr  = 64'h8000_0010;
    in_instr = 32'h104;
    tick();
    check_eq("t2_held_count", 64'(count), 64'd4);
    check_eq("t2_head_instr", 64'(out_instr), 64'h100);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_drain_valid", 64'(out_valid), 64'd1);
      check_eq("t2_drain_addr", out_addr, 64'h8000_0000 + 64'(4 * k));
      acc = in_valid & in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check_eq("t2_end_count", 64'(count), 64'd0);
    check_eq("t2_end_in_valid_drop", 64'(in_valid), 64'd0);

    // 3: ten push/pop pairs across two pointer wraps
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin
        check_eq("t3_addr", out_addr, 64'h8000_1000 + 64'(4 * (i - 1)));
        check_eq("t3_count", 64'(count), 64'd1);
      end
      in_valid = 1'b1;
      in_addr  = 64'h8000_1000 + 64'(4 * i);
      in_instr = 32'h200 + 32'(i);
      tick();
    end
    in_valid = 1'b0;
    check_eq("t3_last_addr", out_addr, 64'h8000_1024);
    check_eq("t3_last_instr", 64'(out_instr), 64'h209);
    tick();
    check_eq("t3_end_count", 64'(count), 64'd0);

    // 4: flush with three entries and a same-cycle push/pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_hold(64'h8000_2000 + 64'(4 * i), 32'h300 + 32'(i));
    end
    check_eq("t4_pre_count", 64'(count), 64'd3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 64'h8000_0100;
    in_instr  = 32'h0BAD;
    out_ready = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("t4_count", 64'(count), 64'd0);
    check_eq("t4_out_valid", 64'(out_valid), 64'd0);
    check_eq("t4_in_ready", 64'(in_ready), 64'd1);
    tick();
    check_eq("t4_still_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    push_hold(64'h8000_3000, 32'h400);
    check_eq("t4_new_addr", out_addr, 64'h8000_3000);
    check_eq("t4_new_count", 64'(count), 64'd1);
    out_ready = 1'b1;
    tick();
    check_eq("t4_drained", 64'(count), 64'd0);

    // 5: full queue with simultaneous push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_hold(64'h8000_4000 + 64'(4 * i), 32'h500 + 32'(i));
    end
    check_eq("t5_full", 64'(count), 64'd4);
    in_valid  = 1'b1;
    in_addr   = 64'h8000_4010;
    in_instr  = 32'h504;
    out_ready = 1'b1;
    tick();
    check_eq("t5_count_after_pop", 64'(count), 64'd3);
    check_eq("t5_head", out_addr, 64'h8000_4004);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_eq("t5_count_refill", 64'(count), 64'd4);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      exp_a = 64'h8000_4000 + 64'(4 * k);
      check_eq("t5_order", out_addr, exp_a);
      check_eq("t5_pc4", out_pcPlus4, exp_a + 64'd4);
      tick();
    end
    check_eq("t5_end_count", 64'(count), 64'd0);

    // 6: empty queue, push with decode ready
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_addr   = 64'h8000_0200;
    in_instr  = 32'h600;
    #1;
`ifdef IF_ID_QUEUE_BYPASS_EN
    check_eq("t6_byp_valid", 64'(out_valid), 64'd1);
    check_eq("t6_byp_addr", out_addr, 64'h8000_0200);
    tick();
    in_valid = 1'b0;
    check_eq("t6_byp_count", 64'(count), 64'd0);
    check_eq("t6_byp_valid_after", 64'(out_valid), 64'd0);
`else
    check_eq("t6_same_cycle_valid", 64'(out_valid), 64'd0);
    tick();
    in_valid = 1'b0;
    check_eq("t6_valid", 64'(out_valid), 64'd1);
    check_eq("t6_addr", out_addr, 64'h8000_0200);
    check_eq("t6_count", 64'(count), 64'd1);
    tick();
    check_eq("t6_count_after", 64'(count), 64'd0);
`endif

    // Reset wins over a same-cycle push, and together with flush
    out_ready = 1'b0;
    push_hold(64'h8000_5000, 32'h700);
    push_hold(64'h8000_5004, 32'h701);
    check_eq("rw_pre_count", 64'(count), 64'd2);
    rst      = 1'b1;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_addr  = 64'h8000_5008;
    tick();
    rst      = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("rw_count", 64'(count), 64'd0);
    check_eq("rw_out_valid", 64'(out_valid), 64'd0);
    check_eq("rw_in_ready", 64'(in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
